// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters and returns the
// registered result on an id-tagged valid/ready response channel.
module alu_share_arbiter #(
  parameter int unsigned          DATA_W    = 16,
  parameter int unsigned          OP_W      = 4,
  parameter logic [OP_W-1:0]      NOP_OP    = 4'hF,
  parameter int unsigned          PRIO_MODE = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [DATA_W-1:0] req0_a_i,
  input  logic [DATA_W-1:0] req0_b_i,
  input  logic [OP_W-1:0]   req0_op_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [DATA_W-1:0] req1_a_i,
  input  logic [DATA_W-1:0] req1_b_i,
  input  logic [OP_W-1:0]   req1_op_i,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [OP_W-1:0]   alu_op_o,
  input  logic [DATA_W-1:0] alu_y_i,
  input  logic              alu_zero_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_id_o,
  output logic [DATA_W-1:0] rsp_y_o,
  output logic              rsp_zero_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              id_q, id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_y_q, rsp_y_d;
  logic              rsp_zero_q, rsp_zero_d;

  logic accept;
  logic grant;
  logic xfer;

  always_comb begin
    accept = (state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready_i);
    if (req1_valid_i && !req0_valid_i) begin
      grant = 1'b1;
    end else if (req0_valid_i && req1_valid_i) begin
      grant = (PRIO_MODE != 0) ? 1'b0 : ~last_grant_q;
    end else begin
      grant = 1'b0;
    end
    xfer = accept && (req0_valid_i || req1_valid_i);
  end

  assign req0_ready_o = accept && !grant;
  assign req1_ready_o = accept && grant;

  // op_q doubles as the ALU opcode register: it only carries a real opcode
  // during the single ISSUE cycle that follows a transfer.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = NOP_OP;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_y_d      = rsp_y_q;
    rsp_zero_d   = rsp_zero_q;

    case (state_q)
      S_IDLE: ;
      S_ISSUE: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_y_d     = alu_y_i;
        rsp_zero_d  = alu_zero_i;
        rsp_id_d    = id_q;
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (xfer) begin
      state_d      = S_ISSUE;
      last_grant_d = grant;
      id_d         = grant;
      a_d          = grant ? req1_a_i  : req0_a_i;
      b_d          = grant ? req1_b_i  : req0_b_i;
      op_d         = grant ? req1_op_i : req0_op_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= NOP_OP;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_y_q      <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_y_q      <= rsp_y_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign alu_a_o     = a_q;
  assign alu_b_o     = b_q;
  assign alu_op_o    = op_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_y_o     = rsp_y_q;
  assign rsp_zero_o  = rsp_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: instance 0 round-robin, instance 1 fixed priority,
// both checked every cycle against a transaction-level reference model.
module tb_alu_share_arbiter;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_PA  = 4'd5;
  localparam logic [3:0] NOP    = 4'hF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v0[2], v1[2], r0[2], r1[2], rr[2];
  logic [15:0] a0[2], b0[2], a1[2], b1[2];
  logic [3:0]  op0[2], op1[2];
  logic [15:0] alu_a[2], alu_b[2], alu_y[2], rsp_y[2];
  logic [3:0]  alu_op[2];
  logic        alu_z[2], rsp_v[2], rsp_id[2], rsp_z[2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_PA:   return a;
      default: return 16'h0000;
    endcase
  endfunction

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      alu_y[k] = alu_f(alu_a[k], alu_b[k], alu_op[k]);
      alu_z[k] = (alu_y[k] == 16'h0000);
    end
  end

  alu_share_arbiter #(.DATA_W(16), .OP_W(4), .NOP_OP(4'hF), .PRIO_MODE(0)) u_rr (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_valid_i(v0[0]), .req0_ready_o(r0[0]), .req0_a_i(a0[0]), .req0_b_i(b0[0]), .req0_op_i(op0[0]),
    .req1_valid_i(v1[0]), .req1_ready_o(r1[0]), .req1_a_i(a1[0]), .req1_b_i(b1[0]), .req1_op_i(op1[0]),
    .alu_a_o(alu_a[0]), .alu_b_o(alu_b[0]), .alu_op_o(alu_op[0]), .alu_y_i(alu_y[0]), .alu_zero_i(alu_z[0]),
    .rsp_valid_o(rsp_v[0]), .rsp_ready_i(rr[0]), .rsp_id_o(rsp_id[0]), .rsp_y_o(rsp_y[0]), .rsp_zero_o(rsp_z[0])
  );

  alu_share_arbiter #(.DATA_W(16), .OP_W(4), .NOP_OP(4'hF), .PRIO_MODE(1)) u_fp (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_valid_i(v0[1]), .req0_ready_o(r0[1]), .req0_a_i(a0[1]), .req0_b_i(b0[1]), .req0_op_i(op0[1]),
    .req1_valid_i(v1[1]), .req1_ready_o(r1[1]), .req1_a_i(a1[1]), .req1_b_i(b1[1]), .req1_op_i(op1[1]),
    .alu_a_o(alu_a[1]), .alu_b_o(alu_b[1]), .alu_op_o(alu_op[1]), .alu_y_i(alu_y[1]), .alu_zero_i(alu_z[1]),
    .rsp_valid_o(rsp_v[1]), .rsp_ready_i(rr[1]), .rsp_id_o(rsp_id[1]), .rsp_y_o(rsp_y[1]), .rsp_zero_o(rsp_z[1])
  );

  // Reference model: an operation in the ALU slot and a response in the output slot.
  logic        infl_v[2], infl_id[2], infl_z[2], out_v[2], out_id[2], out_z[2], last[2];
  logic [15:0] infl_y[2], out_y[2], la[2], lb[2];
  logic [3:0]  infl_op[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic m_grant(input int k);
    if (v1[k] && !v0[k]) return 1'b1;
    if (v0[k] && v1[k]) return (k == 1) ? 1'b0 : ~last[k];
    return 1'b0;
  endfunction

  function automatic logic m_accept(input int k);
    return !infl_v[k] && (!out_v[k] || rr[k]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      infl_v[k] = 0; out_v[k] = 0; last[k] = 1'b1;
      la[k] = 16'h0; lb[k] = 16'h0;
      infl_id[k] = 0; infl_z[k] = 0; infl_y[k] = 0; infl_op[k] = NOP;
      out_id[k] = 0; out_z[k] = 0; out_y[k] = 0;
    end
  endtask

  task automatic model_check(input int k);
    logic g;
    g = m_grant(k);
    if (!m_accept(k)) begin
      chk($sformatf("m%0d_rdy0_blocked", k), r0[k], 0);
      chk($sformatf("m%0d_rdy1_blocked", k), r1[k], 0);
    end else if (v0[k] || v1[k]) begin
      chk($sformatf("m%0d_rdy0", k), r0[k], g == 1'b0);
      chk($sformatf("m%0d_rdy1", k), r1[k], g == 1'b1);
    end
    chk($sformatf("m%0d_rsp_valid", k), rsp_v[k], out_v[k]);
    if (out_v[k]) begin
      chk($sformatf("m%0d_rsp_id", k), rsp_id[k], out_id[k]);
      chk($sformatf("m%0d_rsp_y", k), rsp_y[k], out_y[k]);
      chk($sformatf("m%0d_rsp_zero", k), rsp_z[k], out_z[k]);
    end
    chk($sformatf("m%0d_alu_op", k), alu_op[k], infl_v[k] ? infl_op[k] : NOP);
    chk($sformatf("m%0d_alu_a", k), alu_a[k], la[k]);
    chk($sformatf("m%0d_alu_b", k), alu_b[k], lb[k]);
  endtask

  task automatic model_update(input int k);
    logic g, xf;
    logic [15:0] a, b;
    logic [3:0] op;
    g  = m_grant(k);
    xf = m_accept(k) && (v0[k] || v1[k]);
    if (out_v[k] && rr[k]) out_v[k] = 0;
    if (infl_v[k]) begin
      out_v[k] = 1; out_id[k] = infl_id[k]; out_y[k] = infl_y[k]; out_z[k] = infl_z[k];
      infl_v[k] = 0;
    end
    if (xf) begin
      a  = g ? a1[k] : a0[k];
      b  = g ? b1[k] : b0[k];
      op = g ? op1[k] : op0[k];
      infl_v[k] = 1; infl_id[k] = g; infl_op[k] = op;
      infl_y[k] = alu_f(a, b, op); infl_z[k] = (infl_y[k] == 16'h0);
      la[k] = a; lb[k] = b; last[k] = g;
    end
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic tick();
    #1;
    for (int k = 0; k < 2; k++) begin
      model_check(k);
      model_update(k);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs(input int k);
    v0[k] = 0; v1[k] = 0; a0[k] = 0; b0[k] = 0; a1[k] = 0; b1[k] = 0;
    op0[k] = NOP; op1[k] = NOP; rr[k] = 1;
  endtask

  task automatic reset_check();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst%0d_rsp_valid", k), rsp_v[k], 0);
      chk($sformatf("rst%0d_rsp_id", k), rsp_id[k], 0);
      chk($sformatf("rst%0d_rsp_y", k), rsp_y[k], 0);
      chk($sformatf("rst%0d_rsp_zero", k), rsp_z[k], 0);
      chk($sformatf("rst%0d_alu_a", k), alu_a[k], 0);
      chk($sformatf("rst%0d_alu_b", k), alu_b[k], 0);
      chk($sformatf("rst%0d_alu_op", k), alu_op[k], NOP);
    end
  endtask

  task automatic do_reset();
    for (int k = 0; k < 2; k++) idle_inputs(k);
    rst_n = 0;
    #1;
    reset_check();
    model_reset();
    #1;
    rst_n = 1;
    @(negedge clk);
  endtask

  typedef struct packed {
    logic        v0; logic [15:0] a0; logic [15:0] b0; logic [3:0] op0;
    logic        v1; logic [15:0] a1; logic [15:0] b1; logic [3:0] op1;
    logic        rr; logic rdy_chk; logic e_r0; logic e_r1;
    logic        e_rv; logic e_id; logic [15:0] e_y; logic e_z; logic [3:0] e_op;
  } vec_t;

  vec_t tbl[10];
  logic g_rr[$], g_fp[$];

  initial begin
    rst_n = 0;
    for (int k = 0; k < 2; k++) idle_inputs(k);
    model_reset();

    tbl[0] = '{1'b1, 16'h0003, 16'h0004, OP_ADD, 1'b0, 16'h0, 16'h0, NOP, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, NOP};
    tbl[1] = '{1'b0, 16'h0, 16'h0, NOP, 1'b0, 16'h0, 16'h0, NOP, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, OP_ADD};
    tbl[2] = '{1'b0, 16'h0, 16'h0, NOP, 1'b0, 16'h0, 16'h0, NOP, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0007, 1'b0, NOP};
    tbl[3] = '{1'b0, 16'h0, 16'h0, NOP, 1'b0, 16'h0, 16'h0, NOP, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, NOP};
    tbl[4] = '{1'b0, 16'h0, 16'h0, NOP, 1'b1, 16'h00F0, 16'h000F, OP_OR, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, NOP};
    tbl[5] = '{1'b0, 16'h0, 16'h0, NOP, 1'b0, 16'h0, 16'h0, NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, OP_OR};
    tbl[6] = '{1'b0, 16'h0, 16'h0, NOP, 1'b0, 16'h0, 16'h0, NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h00FF, 1'b0, NOP};
    tbl[7] = '{1'b1, 16'h0005, 16'h0005, OP_SUB, 1'b0, 16'h0, 16'h0, NOP, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h00FF, 1'b0, NOP};
    tbl[8] = '{1'b0, 16'h0, 16'h0, NOP, 1'b0, 16'h0, 16'h0, NOP, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, OP_SUB};
    tbl[9] = '{1'b0, 16'h0, 16'h0, NOP, 1'b0, 16'h0, 16'h0, NOP, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, NOP};

    @(negedge clk);
    do_reset();

    // Directed vectors on the round-robin instance.
    for (int i = 0; i < 10; i++) begin
      v0[0] = tbl[i].v0; a0[0] = tbl[i].a0; b0[0] = tbl[i].b0; op0[0] = tbl[i].op0;
      v1[0] = tbl[i].v1; a1[0] = tbl[i].a1; b1[0] = tbl[i].b1; op1[0] = tbl[i].op1;
      rr[0] = tbl[i].rr;
      #1;
      if (tbl[i].rdy_chk) begin
        chk($sformatf("vec%0d_rdy0", i), r0[0], tbl[i].e_r0);
        chk($sformatf("vec%0d_rdy1", i), r1[0], tbl[i].e_r1);
      end
      chk($sformatf("vec%0d_rsp_valid", i), rsp_v[0], tbl[i].e_rv);
      if (tbl[i].e_rv) begin
        chk($sformatf("vec%0d_rsp_id", i), rsp_id[0], tbl[i].e_id);
        chk($sformatf("vec%0d_rsp_y", i), rsp_y[0], tbl[i].e_y);
        chk($sformatf("vec%0d_rsp_zero", i), rsp_z[0], tbl[i].e_z);
      end
      chk($sformatf("vec%0d_alu_op", i), alu_op[0], tbl[i].e_op);
      tick();
    end

    // Both ports valid continuously: alternation vs fixed priority.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 2; k++) begin
        v0[k] = 1; a0[k] = 16'h0005; b0[k] = 16'h0005; op0[k] = OP_SUB;
        v1[k] = 1; a1[k] = 16'h00F0; b1[k] = 16'h000F; op1[k] = OP_OR;
        rr[k] = 1;
      end
      #1;
      chk("prio_rdy1_low", r1[1], 0);
      if (r0[0]) g_rr.push_back(1'b0); else if (r1[0]) g_rr.push_back(1'b1);
      if (r0[1]) g_fp.push_back(1'b0); else if (r1[1]) g_fp.push_back(1'b1);
      tick();
    end
    chk("rr_grant_count", g_rr.size(), 4);
    chk("fp_grant_count", g_fp.size(), 4);
    for (int i = 0; i < g_rr.size() && i < 4; i++) chk($sformatf("rr_grant%0d", i), g_rr[i], i % 2);
    for (int i = 0; i < g_fp.size() && i < 4; i++) chk($sformatf("fp_grant%0d", i), g_fp[i], 0);
    for (int k = 0; k < 2; k++) idle_inputs(k);
    repeat (3) tick();

    // Backpressure on the round-robin instance with a request waiting.
    v0[0] = 1; a0[0] = 16'h1234; b0[0] = 16'h0001; op0[0] = OP_ADD; rr[0] = 0;
    tick();
    v0[0] = 0;
    tick();
    v1[0] = 1; a1[0] = 16'hAAAA; b1[0] = 16'h5555; op1[0] = OP_XOR;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_rsp_valid", rsp_v[0], 1);
      chk("bp_rsp_y", rsp_y[0], 16'h1235);
      chk("bp_rsp_id", rsp_id[0], 0);
      chk("bp_rdy0", r0[0], 0);
      chk("bp_rdy1", r1[0], 0);
      tick();
    end
    rr[0] = 1;
    #1;
    chk("bp_release_rdy1", r1[0], 1);
    tick();
    v1[0] = 0;
    repeat (3) tick();

    // Asynchronous reset in the middle of ISSUE.
    for (int k = 0; k < 2; k++) begin
      v0[k] = 1; a0[k] = 16'h0009; b0[k] = 16'h0009; op0[k] = OP_AND; rr[k] = 1;
    end
    tick();
    for (int k = 0; k < 2; k++) v0[k] = 0;
    #1;
    chk("issue_before_rst_op", alu_op[0], OP_AND);
    #2;
    rst_n = 0;
    #1;
    reset_check();
    model_reset();
    @(negedge clk);
    rst_n = 1;
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      v0[k] = 1; a0[k] = 16'h0011; b0[k] = 16'h0022; op0[k] = OP_ADD;
      v1[k] = 1; a1[k] = 16'h0033; b1[k] = 16'h0044; op1[k] = OP_ADD;
    end
    #1;
    chk("post_rst_tie_rr", r0[0], 1);
    chk("post_rst_tie_fp", r0[1], 1);
    tick();
    for (int k = 0; k < 2; k++) idle_inputs(k);
    repeat (4) tick();

    // Idle cycles: operands held, NOP driven.
    chk("idle_alu_a_hold", alu_a[0], 16'h0011);
    chk("idle_alu_op", alu_op[0], NOP);

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < 2; k++) begin
        v0[k]  = ($urandom_range(0, 2) != 0);
        v1[k]  = ($urandom_range(0, 2) != 0);
        a0[k]  = 16'($urandom);
        b0[k]  = ($urandom_range(0, 3) == 0) ? a0[k] : 16'($urandom);
        op0[k] = 4'($urandom_range(0, 5));
        a1[k]  = 16'($urandom);
        b1[k]  = ($urandom_range(0, 3) == 0) ? a1[k] : 16'($urandom);
        op1[k] = 4'($urandom_range(0, 5));
        rr[k]  = ($urandom_range(0, 3) != 0);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
